dcache_ctrl: RTL and testbench

Direct-mapped, write-through, read-allocate data cache controller between the CPU's `dcache_*` load/store port and a single-word memory bus with request/acknowledge handshake. It services hits without stalling and sequences 4-word line refills on read misses. Stores are written through to memory, with the cached copy updated on a hit. `stall_o` back-pressures the CPU pipeline whenever a request cannot complete in the current cycle.

---
 rtl/dcache_pkg.sv | 24 ++
 rtl/dcache_data_ram.sv | 33 +++
 rtl/dcache_ctrl.sv | 163 ++++++++++++++++
 tb/tb_dcache_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types, constants and address field helpers for the data cache.
package dcache_pkg;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE, DONE} state_t;

  localparam int WORDS_PER_LINE = 4;
  localparam int OFFSET_BITS    = 4;

  // Tag field: everything above index and line offset.
  function automatic logic [31:0] addr_tag(input logic [31:0] a, input int index_bits);
    return a >> (OFFSET_BITS + index_bits);
  endfunction

  // Line index field, right-justified.
  function automatic logic [31:0] addr_index(input logic [31:0] a, input int index_bits);
    return (a >> OFFSET_BITS) & ((32'd1 << index_bits) - 32'd1);
  endfunction

  // Word within the line.
  function automatic logic [1:0] addr_word(input logic [31:0] a);
    return a[3:2];
  endfunction

endpackage

// File: rtl/dcache_data_ram.sv
// Line data storage: async read, sync write with per-byte enables.
module dcache_data_ram
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] widx,
  input  logic [1:0]            wword,
  input  logic [3:0]            wbe,
  input  logic [31:0]           wdata,
  input  logic [INDEX_BITS-1:0] ridx,
  input  logic [1:0]            rword,
  output logic [31:0]           rdata
);

  localparam int DEPTH = (1 << INDEX_BITS) * WORDS_PER_LINE;

  logic [31:0] mem [DEPTH];

  // Byte-masked write; only enabled lanes change.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wbe[b]) mem[{widx, wword}][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = mem[{ridx, rword}];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through read-allocate data cache controller.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dcache_rreq_i,
  input  logic [31:0] dcache_raddr_i,
  input  logic        dcache_wreq_i,
  input  logic [31:0] dcache_waddr_i,
  input  logic [31:0] dcache_wdata_i,
  input  logic [3:0]  dcache_wsel_i,
  output logic [31:0] dcache_data_o,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wsel_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 32 - OFFSET_BITS - INDEX_BITS;

  state_t                state_q, state_d;
  logic [1:0]            cnt_q;
  logic                  cnt_clr, cnt_inc, line_fill;
  logic [LINES-1:0]      valid_q;
  logic [TAG_W-1:0]      tag_q [LINES];

  logic [31:0]           req_addr;
  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      tag_in;
  logic [1:0]            word;
  logic                  hit;
  logic                  issue_wr;

  logic                  ram_we;
  logic [1:0]            ram_wword;
  logic [3:0]            ram_be;
  logic [31:0]           ram_wdata, ram_rdata;

  // Store wins when the CPU (illegally) raises both requests.
  assign req_addr = dcache_wreq_i ? dcache_waddr_i : dcache_raddr_i;
  assign idx      = INDEX_BITS'(addr_index(req_addr, INDEX_BITS));
  assign tag_in   = TAG_W'(addr_tag(req_addr, INDEX_BITS));
  assign word     = addr_word(req_addr);
  assign hit      = valid_q[idx] && (tag_q[idx] == tag_in);

  dcache_data_ram #(.INDEX_BITS(INDEX_BITS)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .widx  (idx),
    .wword (ram_wword),
    .wbe   (ram_be),
    .wdata (ram_wdata),
    .ridx  (idx),
    .rword (word),
    .rdata (ram_rdata)
  );

  // Next-state, bus drive and array write control.
  always_comb begin
    state_d       = state_q;
    stall_o       = 1'b0;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    mem_wsel_o    = '0;
    dcache_data_o = '0;
    ram_we        = 1'b0;
    ram_wword     = word;
    ram_be        = '0;
    ram_wdata     = '0;
    cnt_clr       = 1'b0;
    cnt_inc       = 1'b0;
    line_fill     = 1'b0;
    issue_wr      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dcache_wreq_i) begin
          // The write goes out in the lookup cycle so a zero-latency
          // ack retires the store after a single stall cycle.
          issue_wr = 1'b1;
          state_d  = mem_ack_i ? DONE : WRITE;
        end else if (dcache_rreq_i) begin
          if (hit) begin
            dcache_data_o = ram_rdata;
          end else begin
            stall_o = 1'b1;
            cnt_clr = 1'b1;
            state_d = REFILL;
          end
        end
      end
      REFILL: begin
        stall_o    = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = {dcache_raddr_i[31:4], cnt_q, 2'b00};
        if (mem_ack_i) begin
          ram_we    = 1'b1;
          ram_be    = 4'hF;
          ram_wdata = mem_rdata_i;
          ram_wword = cnt_q;
          cnt_inc   = 1'b1;
          if (cnt_q == 2'(WORDS_PER_LINE - 1)) begin
            line_fill = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      WRITE: begin
        issue_wr = 1'b1;
        if (mem_ack_i) state_d = DONE;
      end
      DONE: begin
        // Retire cycle; the still-held store must not be replayed.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (issue_wr) begin
      stall_o     = 1'b1;
      mem_req_o   = 1'b1;
      mem_we_o    = 1'b1;
      mem_addr_o  = {dcache_waddr_i[31:2], 2'b00};
      mem_wdata_o = dcache_wdata_i;
      mem_wsel_o  = dcache_wsel_i;
      // Write-through: refresh the cached copy only on a hit, no allocate.
      if (mem_ack_i && hit) begin
        ram_we    = 1'b1;
        ram_be    = dcache_wsel_i;
        ram_wdata = dcache_wdata_i;
      end
    end
  end

  // State, refill counter and valid bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      if (cnt_clr)      cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + 2'd1;
      if (line_fill) valid_q[idx] <= 1'b1;
    end
  end

  // Tags are qualified by valid bits, so they need no reset.
  always_ff @(posedge clk) begin
    if (line_fill) tag_q[idx] <= tag_in;
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a latency-programmable memory responder.
module tb_dcache_ctrl;
  import dcache_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rreq = 1'b0, wreq = 1'b0;
  logic [31:0] raddr = '0, waddr = '0, wdata = '0;
  logic [3:0]  wsel = '0;
  logic [31:0] dcache_data_o;
  logic        stall_o, mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_wsel_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  int total = 0;
  int bad   = 0;
  int lat   = 2;
  int wcnt  = 0;

  logic [31:0] b_addr[$], b_wdata[$];
  logic        b_we[$];
  logic [3:0]  b_wsel[$];
  logic [31:0] bmem [logic [31:0]];

  dcache_ctrl #(.INDEX_BITS(6)) dut (
    .clk(clk), .rst(rst),
    .dcache_rreq_i(rreq), .dcache_raddr_i(raddr),
    .dcache_wreq_i(wreq), .dcache_waddr_i(waddr),
    .dcache_wdata_i(wdata), .dcache_wsel_i(wsel),
    .dcache_data_o(dcache_data_o), .stall_o(stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wsel_o(mem_wsel_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return bmem.exists(a) ? bmem[a] : (a ^ 32'h5A5A_0000);
  endfunction

  // Memory: acks after lat extra cycles, logs every completed access.
  always @(negedge clk) begin
    logic [31:0] w;
    mem_ack_i = 1'b0;
    if (rst || !mem_req_o) begin
      wcnt = 0;
    end else if (wcnt >= lat) begin
      wcnt = 0;
      mem_ack_i = 1'b1;
      b_addr.push_back(mem_addr_o);
      b_we.push_back(mem_we_o);
      b_wsel.push_back(mem_wsel_o);
      b_wdata.push_back(mem_wdata_o);
      if (mem_we_o) begin
        w = rd(mem_addr_o);
        for (int b = 0; b < 4; b++)
          if (mem_wsel_o[b]) w[b*8 +: 8] = mem_wdata_o[b*8 +: 8];
        bmem[mem_addr_o] = w;
      end else begin
        mem_rdata_i = rd(mem_addr_o);
      end
    end else begin
      wcnt++;
    end
  end

  // The CPU must never raise load and store together.
  always @(negedge clk) begin
    if (!rst) assert (!(rreq && wreq)) else begin
      bad++;
      $error("FAIL rw_overlap: observed both requests, expected at most one");
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input string tag, input logic [31:0] a, input logic [31:0] exp_d,
                         input int exp_stall, input int exp_bus);
    int st, n0;
    st = 0; n0 = b_addr.size();
    raddr = a; rreq = 1'b1;
    @(negedge clk); #1;
    while (stall_o && st < 200) begin
      st++; @(negedge clk); #1;
    end
    chk({tag, "_data"}, dcache_data_o, exp_d);
    chk({tag, "_stall"}, 32'(st), 32'(exp_stall));
    chk({tag, "_bus"}, 32'(b_addr.size() - n0), 32'(exp_bus));
    @(posedge clk); #1;
    rreq = 1'b0;
  endtask

  task automatic do_store(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be, input int exp_stall);
    int st, n0;
    st = 0; n0 = b_addr.size();
    waddr = a; wdata = d; wsel = be; wreq = 1'b1;
    @(negedge clk); #1;
    while (stall_o && st < 200) begin
      st++; @(negedge clk); #1;
    end
    chk({tag, "_stall"}, 32'(st), 32'(exp_stall));
    @(posedge clk); #1;
    wreq = 1'b0;
    chk({tag, "_bus"}, 32'(b_addr.size() - n0), 32'd1);
    if (b_addr.size() > n0) begin
      chk({tag, "_we"}, 32'(b_we[n0]), 32'd1);
      chk({tag, "_addr"}, b_addr[n0], a);
      chk({tag, "_wsel"}, 32'(b_wsel[n0]), 32'(be));
      chk({tag, "_wdata"}, b_wdata[n0], d);
    end
  endtask

  initial begin
    int n0, guard;
    bmem[32'h1000] = 32'hA0; bmem[32'h1004] = 32'hA1;
    bmem[32'h1008] = 32'hA2; bmem[32'h100C] = 32'hA3;

    // Reset state
    #12;
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_we", 32'(mem_we_o), 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_data", dcache_data_o, 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    @(posedge clk); #1 rst = 1'b0;

    // Cold miss, L=2
    lat = 2; n0 = b_addr.size();
    do_load("cold", 32'h1004, 32'hA1, 13, 4);
    chk("cold_a0", b_addr[n0],   32'h1000);
    chk("cold_a1", b_addr[n0+1], 32'h1004);
    chk("cold_a2", b_addr[n0+2], 32'h1008);
    chk("cold_a3", b_addr[n0+3], 32'h100C);
    chk("cold_rd", 32'(b_we[n0] | b_we[n0+3]), 32'd0);
    do_load("hit_c", 32'h100C, 32'hA3, 0, 0);

    // Back-to-back hits, one per cycle
    raddr = 32'h1000; rreq = 1'b1;
    @(negedge clk); #1;
    chk("b2b0_d", dcache_data_o, 32'hA0); chk("b2b0_s", 32'(stall_o), 32'd0);
    @(posedge clk); #1 raddr = 32'h1004;
    @(negedge clk); #1;
    chk("b2b1_d", dcache_data_o, 32'hA1); chk("b2b1_s", 32'(stall_o), 32'd0);
    @(posedge clk); #1 raddr = 32'h1008;
    @(negedge clk); #1;
    chk("b2b2_d", dcache_data_o, 32'hA2); chk("b2b2_s", 32'(stall_o), 32'd0);
    @(posedge clk); #1 rreq = 1'b0;

    // Store hit, partial bytes
    do_store("st_hit", 32'h1008, 32'h1234_5678, 4'b0011, 3);
    do_load("st_hit_rd", 32'h1008, 32'h0000_5678, 0, 0);

    // Zero-enable store leaves the array alone
    lat = 1;
    do_store("st_z", 32'h1004, 32'hFFFF_FFFF, 4'b0000, 2);
    do_load("st_z_rd", 32'h1004, 32'hA1, 0, 0);

    // Store miss does not allocate; later load refills written data
    do_store("st_miss", 32'h2000, 32'hCAFE_BABE, 4'b1111, 2);
    do_load("st_miss_rd", 32'h2000, 32'hCAFE_BABE, 9, 4);

    // Reset after the second refill ack
    n0 = b_addr.size(); guard = 0;
    raddr = 32'h5000; rreq = 1'b1;
    while (b_addr.size() < n0 + 2 && guard < 100) begin
      @(negedge clk); guard++;
    end
    chk("mr_acks", 32'(b_addr.size() - n0), 32'd2);
    @(posedge clk); #1 rst = 1'b1; rreq = 1'b0;
    #1;
    chk("mr_req", 32'(mem_req_o), 32'd0);
    chk("mr_state", 32'(dut.state_q), 32'(IDLE));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n0 = b_addr.size();
    do_load("mr_reload", 32'h5000, 32'h5A5A_5000, 9, 4);
    chk("mr_a0", b_addr[n0], 32'h5000);

    // Conflict eviction: same index, two tags
    n0 = b_addr.size();
    do_load("cf1", 32'h1000, 32'hA0, 9, 4);
    do_load("cf2", 32'h1400, 32'h5A5A_1400, 9, 4);
    do_load("cf3", 32'h1000, 32'hA0, 9, 4);
    chk("cf_reads", 32'(b_addr.size() - n0), 32'd12);

    // Zero-latency ack
    lat = 0;
    do_store("z_st", 32'h100C, 32'h1111_1111, 4'b1111, 1);
    do_load("z_hit", 32'h100C, 32'h1111_1111, 0, 0);
    do_load("z_miss", 32'h3000, 32'h5A5A_3000, 5, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
